spi_flash_cmd_sequencer: RTL and testbench
==========================================

Name: spi_flash_cmd_sequencer

Overview:
- Shares one byte-level SPI NOR flash engine between two requesters, e.g. the APB slave path and a DMA/boot fetcher.
- Arbitrates round-robin, then sequences complete flash command frames on the engine:
  - READ (0x03)
  - WREN (0x06) + PAGE PROGRAM (0x02)
  - RDSR (0x05) busy polling
- Returns a single response per request, with 32-bit data.

Parameters:
- CS_GAP, 2: minimum p_clk cycles s_css is held high between frames.
- POLL_MAX, 16'd1000: maximum RDSR status bytes before a write times out.

Ports:
- p_clk  in  1  system clock, all logic on rising edge.
- p_reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request; held until the matching req_ready.
- req_write  in  2  per-requester: 1 = program, 0 = read.
- req_addr  in  48  {req1 addr[23:0], req0 addr[23:0]} flash byte address.
- req_wdata  in  64  {req1 data, req0 data}; 32-bit write data.
- req_ready  out  2  one-cycle accept pulse to the granted requester.
- rsp_valid  out  2  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data, MSB byte first from flash; 0 after a write.
- rsp_err  out  1  valid with rsp_valid; 1 = RDSR poll timeout.
- s_css  out  1  flash chip select, active low.
- s_tx_valid  out  1  byte request to the SPI byte engine.
- s_tx_byte  out  8  byte to shift out on MOSI.
- s_byte_done  in  1  engine pulse: byte exchanged; s_rx_byte is valid this cycle.
- s_rx_byte  in  8  byte received on MISO.

Behaviour:

Reset (asynchronous, takes effect immediately, including mid-frame):
- s_css=1, s_tx_valid=0, s_tx_byte=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- RR pointer=0 (req0 favoured), state=IDLE. An in-flight transaction is abandoned with no response.

States: IDLE, WREN, GAP1, CMD, ADDR, DATA, GAP2, RDSR, POLL, DONE.

Arbitration (IDLE only):
- If exactly one req_valid bit is set, that requester wins.
- If both are set, the requester at the RR pointer wins; the pointer then moves to the other requester.
- On the grant edge, write/addr/wdata are latched and the owner is recorded.
- req_ready[owner] is high for exactly the next cycle.
- The transaction is atomic: no re-arbitration until DONE.

Byte handshake:
- In a byte state, s_tx_valid=1 with s_tx_byte stable until s_byte_done.
- On the s_byte_done cycle the state or byte index advances. s_tx_valid drops for at least 1 cycle between bytes.
- s_byte_done while s_tx_valid=0 is ignored.
- s_css goes low one cycle before the first s_tx_valid of a frame and goes high the cycle after the last byte's s_byte_done.

Read path (one frame):
- CMD sends 0x03.
- ADDR sends 3 bytes: addr[23:16], [15:8], [7:0].
- DATA sends 4 bytes of 0x00; s_rx_byte fills rdata[31:24], [23:16], [15:8], [7:0] in order.
- Then DONE.

Write path:
- WREN frame: 0x06 (one byte), then GAP1 with s_css high for CS_GAP cycles.
- Program frame: CMD 0x02, ADDR 3 bytes, DATA sends wdata[31:24]..[7:0]. Received bytes are discarded.
- GAP2: CS_GAP cycles.
- RDSR frame: 0x05, then POLL sends 0x00 bytes while s_css stays low.
- Each POLL byte with s_rx_byte[0]=0 (WIP clear) ends the frame and goes to DONE, err=0.
- If POLL_MAX status bytes all return WIP=1, the frame ends and goes to DONE, err=1.

DONE:
- rsp_valid[owner]=1 for one cycle; rsp_rdata/rsp_err are registered and held until the next response.
- Return to IDLE next cycle. A new grant is possible on the first IDLE cycle.

Other rules:
- Minimum frame spacing is CS_GAP, also between back-to-back transactions (IDLE counts toward the gap).
- Request inputs are ignored outside IDLE; a requester whose valid drops before ready is simply not served.

Test Plan:
1. Read, req0, addr 0x000000; flash returns 0xFF,0x00,0xFF,0x00 → MOSI 03,00,00,00,00×4, one s_css low window, rsp_valid[0] pulse, rsp_rdata=0xFF00FF00, err=0.
2. Write, req1, addr 0x000100, wdata 0xFF00FF00; status 0x01,0x01,0x00 → three frames: [06], [02,00,01,00,FF,00,FF,00], [05,00,00,00]; each gap ≥2 cycles; rsp_valid[1] pulse, rdata=0, err=0.
3. Both req_valid high from reset → req0 granted first, req1 granted on the first IDLE after req0's rsp; ready/rsp pulses go to the correct bit. Repeat both-valid → req1 first (pointer moved).
4. Write with status stuck at 0x01, POLL_MAX=4 → exactly 4 POLL bytes after 0x05, then s_css high, rsp_err=1.
5. Assert p_reset during ADDR byte 2 → same cycle: s_css=1, s_tx_valid=0; no rsp_valid. After release, a fresh req0 read completes normally.
6. Stray s_byte_done pulses in IDLE and GAP → no state change, no MOSI byte, no response.

Source files
------------

// File: rtl/spi_flash_cmd_sequencer_if.sv
// Request/response and SPI byte-engine bundle for the flash sequencer.
// slave: sequencer side; master: requesters plus byte engine side.
interface spi_flash_cmd_sequencer_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [47:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        s_css;
   logic        s_tx_valid;
   logic [7:0]  s_tx_byte;
   logic        s_byte_done;
   logic [7:0]  s_rx_byte;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  s_byte_done, s_rx_byte,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output s_css, s_tx_valid, s_tx_byte
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output s_byte_done, s_rx_byte,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  s_css, s_tx_valid, s_tx_byte
   );
endinterface

// File: rtl/spi_flash_cmd_sequencer.sv
// Round-robin sharing of one SPI NOR byte engine between two requesters;
// sequences READ, WREN+PROGRAM and RDSR polling frames.
// Ports: p_clk, p_reset (async, active high), bus (slave modport):
//   req_* requests in, req_ready/rsp_* out, s_* byte engine link.
module spi_flash_cmd_sequencer #(
   parameter int          CS_GAP   = 2,
   parameter logic [15:0] POLL_MAX = 16'd1000
) (
   input logic                      p_clk,
   input logic                      p_reset,
   spi_flash_cmd_sequencer_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, WREN, GAP1, CMD, ADDR, DATA, GAP2, RDSR, POLL, DONE
   } state_t;

   state_t      state, state_n;
   logic        tx_on, tx_on_n;
   logic [1:0]  idx, idx_n;
   logic [15:0] pcnt, pcnt_n;
   logic [7:0]  hi_cnt, hi_cnt_n;
   logic        rr, rr_n;
   logic        owner, owner_n;
   logic        wr, wr_n;
   logic [23:0] addr, addr_n;
   logic [31:0] wdata, wdata_n;
   logic [31:0] rd, rd_n;
   logic [1:0]  ready, ready_n;
   logic [31:0] rdata, rdata_n;
   logic        err, err_n;
   logic        byte_st, done, gap_ok, win;
   logic [7:0]  tx_sel;

   assign byte_st = state inside {WREN, CMD, ADDR, DATA, RDSR, POLL};
   assign done    = tx_on & bus.s_byte_done;
   // hi_cnt counts prior chip-select-high cycles; the current one counts too
   assign gap_ok  = (int'(hi_cnt) + 1) >= CS_GAP;

   assign bus.s_css      = ~byte_st;
   assign bus.s_tx_valid = tx_on;
   assign bus.s_tx_byte  = tx_on ? tx_sel : 8'h00;
   assign bus.req_ready  = ready;
   assign bus.rsp_valid  = (state == DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_rdata  = rdata;
   assign bus.rsp_err    = err;

   always_comb begin
      tx_sel = 8'h00;
      unique case (state)
         WREN: tx_sel = 8'h06;
         CMD:  tx_sel = wr ? 8'h02 : 8'h03;
         ADDR: begin
            unique case (idx)
               2'd0:    tx_sel = addr[23:16];
               2'd1:    tx_sel = addr[15:8];
               default: tx_sel = addr[7:0];
            endcase
         end
         DATA: begin
            if (wr) begin
               unique case (idx)
                  2'd0:    tx_sel = wdata[31:24];
                  2'd1:    tx_sel = wdata[23:16];
                  2'd2:    tx_sel = wdata[15:8];
                  default: tx_sel = wdata[7:0];
               endcase
            end
         end
         RDSR:    tx_sel = 8'h05;
         default: tx_sel = 8'h00;
      endcase
   end

   always_comb begin
      state_n  = state;
      tx_on_n  = 1'b0;
      idx_n    = idx;
      pcnt_n   = pcnt;
      rr_n     = rr;
      owner_n  = owner;
      wr_n     = wr;
      addr_n   = addr;
      wdata_n  = wdata;
      rd_n     = rd;
      ready_n  = 2'b00;
      rdata_n  = rdata;
      err_n    = err;
      win      = 1'b0;
      hi_cnt_n = 8'd0;
      if (bus.s_css)
         hi_cnt_n = (hi_cnt == 8'hFF) ? hi_cnt : hi_cnt + 8'd1;
      // first cycle of each byte state keeps tx_valid low, giving the
      // select-before-data cycle and the idle cycle between bytes
      if (byte_st)
         tx_on_n = ~done;
      unique case (state)
         IDLE: begin
            if (gap_ok && (|bus.req_valid)) begin
               win = (bus.req_valid == 2'b11) ? rr : bus.req_valid[1];
               if (bus.req_valid == 2'b11)
                  rr_n = ~rr;
               owner_n = win;
               wr_n    = bus.req_write[win];
               addr_n  = win ? bus.req_addr[47:24] : bus.req_addr[23:0];
               wdata_n = win ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
               rd_n    = 32'd0;
               ready_n = win ? 2'b10 : 2'b01;
               state_n = bus.req_write[win] ? WREN : CMD;
            end
         end
         WREN: if (done) state_n = GAP1;
         GAP1: if (gap_ok) state_n = CMD;
         CMD: begin
            if (done) begin
               state_n = ADDR;
               idx_n   = 2'd0;
            end
         end
         ADDR: begin
            if (done) begin
               if (idx == 2'd2) begin
                  state_n = DATA;
                  idx_n   = 2'd0;
               end else begin
                  idx_n = idx + 2'd1;
               end
            end
         end
         DATA: begin
            if (done) begin
               if (!wr)
                  rd_n = {rd[23:0], bus.s_rx_byte};
               if (idx == 2'd3) begin
                  if (wr) begin
                     state_n = GAP2;
                  end else begin
                     state_n = DONE;
                     rdata_n = {rd[23:0], bus.s_rx_byte};
                     err_n   = 1'b0;
                  end
               end else begin
                  idx_n = idx + 2'd1;
               end
            end
         end
         GAP2: if (gap_ok) state_n = RDSR;
         RDSR: begin
            if (done) begin
               state_n = POLL;
               pcnt_n  = 16'd0;
            end
         end
         POLL: begin
            if (done) begin
               if (!bus.s_rx_byte[0]) begin
                  state_n = DONE;
                  rdata_n = 32'd0;
                  err_n   = 1'b0;
               end else if ((pcnt + 16'd1) >= POLL_MAX) begin
                  state_n = DONE;
                  rdata_n = 32'd0;
                  err_n   = 1'b1;
               end else begin
                  pcnt_n = pcnt + 16'd1;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge p_clk or posedge p_reset) begin
      if (p_reset) begin
         state  <= IDLE;
         tx_on  <= 1'b0;
         idx    <= 2'd0;
         pcnt   <= 16'd0;
         hi_cnt <= 8'hFF;
         rr     <= 1'b0;
         owner  <= 1'b0;
         wr     <= 1'b0;
         addr   <= 24'd0;
         wdata  <= 32'd0;
         rd     <= 32'd0;
         ready  <= 2'b00;
         rdata  <= 32'd0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         tx_on  <= tx_on_n;
         idx    <= idx_n;
         pcnt   <= pcnt_n;
         hi_cnt <= hi_cnt_n;
         rr     <= rr_n;
         owner  <= owner_n;
         wr     <= wr_n;
         addr   <= addr_n;
         wdata  <= wdata_n;
         rd     <= rd_n;
         ready  <= ready_n;
         rdata  <= rdata_n;
         err    <= err_n;
      end
   end
endmodule

// File: tb/tb_spi_flash_cmd_sequencer.sv
// Self-checking bench for spi_flash_cmd_sequencer: byte-engine model,
// frame monitor, table vectors, corner sequences and random traffic.
module tb_spi_flash_cmd_sequencer;
   localparam int CS_GAP = 2;
   localparam int PMAX   = 4;
   localparam int END    = 256;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_flash_cmd_sequencer_if bus ();

   spi_flash_cmd_sequencer #(
      .CS_GAP   (CS_GAP),
      .POLL_MAX (16'd4)
   ) dut (
      .p_clk   (clk),
      .p_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      bit          wr;
      int          who;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] fdata;
      int          busy;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   int errors = 0;
   int checks = 0;

   int   exp_mosi[$];
   int   mosi_log[$];
   logic [7:0] rxq[$];
   bit   stray = 0;
   int   max_dly = 0;
   int   rr_exp = 0;

   int rdy_cnt[2];
   int rsp_cnt[2];
   int rdy_cyc[2];
   int rsp_cyc[2];
   int cyc = 0;
   int viol = 0;
   int css_low_cyc = 0;
   logic [31:0] cap_rdata = 32'd0;
   logic        cap_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // byte engine: answers each tx byte after a random latency
   initial begin
      int dly;
      dly = 0;
      bus.s_byte_done = 1'b0;
      bus.s_rx_byte = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         bus.s_byte_done = 1'b0;
         if (rst) begin
            dly = 0;
         end else if (bus.s_tx_valid) begin
            if (dly > 0) begin
               dly--;
            end else begin
               bus.s_byte_done = 1'b1;
               bus.s_rx_byte = (rxq.size() > 0) ? rxq.pop_front() : 8'h01;
               dly = $urandom_range(0, max_dly);
            end
         end else if (stray && ($urandom_range(0, 2) == 0)) begin
            bus.s_byte_done = 1'b1;
            bus.s_rx_byte = 8'($urandom);
         end
      end
   end

   // monitor: frames, gaps, pulses
   initial begin
      bit prev_css, seen_frame;
      int hi_run;
      prev_css = 1'b1;
      seen_frame = 1'b0;
      hi_run = 0;
      for (int b = 0; b < 2; b++) begin
         rdy_cnt[b] = 0; rsp_cnt[b] = 0;
         rdy_cyc[b] = 0; rsp_cyc[b] = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_css = 1'b1;
            seen_frame = 1'b0;
            hi_run = 0;
         end else begin
            if (bus.s_tx_valid && bus.s_byte_done)
               mosi_log.push_back(int'(bus.s_tx_byte));
            if (!bus.s_css) css_low_cyc++;
            if (!bus.s_css && prev_css) begin
               if (seen_frame && hi_run < CS_GAP) viol++;
               if (bus.s_tx_valid) viol++;
            end
            if (bus.s_css && !prev_css) begin
               mosi_log.push_back(END);
               seen_frame = 1'b1;
            end
            if (bus.s_css) begin
               hi_run++;
               if (bus.s_tx_valid) viol++;
            end else begin
               hi_run = 0;
            end
            if (bus.rsp_valid == 2'b11) viol++;
            for (int b = 0; b < 2; b++) begin
               if (bus.req_ready[b]) begin
                  rdy_cnt[b]++;
                  rdy_cyc[b] = cyc;
               end
               if (bus.rsp_valid[b]) begin
                  rsp_cnt[b]++;
                  rsp_cyc[b] = cyc;
                  cap_rdata = bus.rsp_rdata;
                  cap_err = bus.rsp_err;
               end
            end
            prev_css = bus.s_css;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // reference: expected MOSI frames and the flash's MISO bytes
   task automatic model_txn(input bit wr, input logic [23:0] a,
                            input logic [31:0] wd, input logic [31:0] fd,
                            input int busy, input bit noisy);
      int polls;
      if (!wr) begin
         exp_mosi.push_back(3);
         for (int i = 2; i >= 0; i--) exp_mosi.push_back(int'(a[8*i +: 8]));
         for (int i = 0; i < 4; i++) exp_mosi.push_back(0);
         exp_mosi.push_back(END);
         for (int i = 0; i < 4; i++) rxq.push_back(8'($urandom));
         for (int i = 3; i >= 0; i--) rxq.push_back(fd[8*i +: 8]);
      end else begin
         polls = (busy < PMAX) ? busy + 1 : PMAX;
         exp_mosi.push_back(6);
         exp_mosi.push_back(END);
         exp_mosi.push_back(2);
         for (int i = 2; i >= 0; i--) exp_mosi.push_back(int'(a[8*i +: 8]));
         for (int i = 3; i >= 0; i--) exp_mosi.push_back(int'(wd[8*i +: 8]));
         exp_mosi.push_back(END);
         exp_mosi.push_back(5);
         for (int i = 0; i < polls; i++) exp_mosi.push_back(0);
         exp_mosi.push_back(END);
         for (int i = 0; i < 10; i++) rxq.push_back(8'($urandom));
         for (int i = 0; i < polls; i++) begin
            if (i < busy) rxq.push_back(noisy ? (8'($urandom) | 8'h01) : 8'h01);
            else rxq.push_back(noisy ? (8'($urandom) & 8'hFE) : 8'h00);
         end
      end
   endtask

   task automatic set_req(input int who, input bit v, input bit wr,
                          input logic [23:0] a, input logic [31:0] wd);
      bus.req_valid[who] = v;
      bus.req_write[who] = wr;
      bus.req_addr[24*who +: 24] = a;
      bus.req_wdata[32*who +: 32] = wd;
   endtask

   task automatic wait_rdy(input int who, input int base, input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         #1;
         got = (rdy_cnt[who] != base);
      end
      chk({tag, " ready_seen"}, 64'(got), 64'd1);
   endtask

   task automatic wait_rsp(input int who, input int base, input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(posedge clk);
         #1;
         got = (rsp_cnt[who] != base);
      end
      chk({tag, " rsp_seen"}, 64'(got), 64'd1);
   endtask

   task automatic chk_frames(input string tag);
      int n;
      n = 0;
      while (n < exp_mosi.size() && n < mosi_log.size()
             && exp_mosi[n] == mosi_log[n]) n++;
      chk({tag, " frame_len"}, 64'(mosi_log.size()), 64'(exp_mosi.size()));
      chk({tag, " frame_bytes"}, 64'(n), 64'(exp_mosi.size()));
      chk({tag, " cs_rules"}, 64'(viol), 64'd0);
   endtask

   task automatic start_txn();
      exp_mosi.delete();
      rxq.delete();
      @(posedge clk);
      #1;
      mosi_log.delete();
      viol = 0;
   endtask

   task automatic run_txn(input bit wr, input int who, input logic [23:0] a,
                          input logic [31:0] wd, input logic [31:0] fd,
                          input int busy, input bit noisy,
                          input logic [31:0] er, input bit ee,
                          input string tag);
      int rb[2], sb[2];
      start_txn();
      model_txn(wr, a, wd, fd, busy, noisy);
      for (int b = 0; b < 2; b++) begin
         rb[b] = rdy_cnt[b];
         sb[b] = rsp_cnt[b];
      end
      set_req(who, 1'b1, wr, a, wd);
      wait_rdy(who, rb[who], tag);
      set_req(who, 1'b0, 1'($urandom), 24'($urandom), $urandom);
      wait_rsp(who, sb[who], tag);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " rdata"}, 64'(cap_rdata), 64'(er));
      chk({tag, " err"}, 64'(cap_err), 64'(ee));
      chk({tag, " rdata_held"}, 64'(bus.rsp_rdata), 64'(er));
      chk({tag, " rsp_own"}, 64'(rsp_cnt[who] - sb[who]), 64'd1);
      chk({tag, " rsp_other"}, 64'(rsp_cnt[1-who] - sb[1-who]), 64'd0);
      chk({tag, " rdy_own"}, 64'(rdy_cnt[who] - rb[who]), 64'd1);
      chk({tag, " rdy_other"}, 64'(rdy_cnt[1-who] - rb[1-who]), 64'd0);
      chk_frames(tag);
   endtask

   // both requesters valid at once; winner predicted from rr_exp
   task automatic both_round(input string tag);
      int first, second;
      logic [23:0] a[2];
      logic [31:0] d[2];
      int rb[2], sb[2];
      bit got;
      first = rr_exp;
      second = 1 - first;
      rr_exp = second;
      start_txn();
      for (int b = 0; b < 2; b++) begin
         a[b] = 24'($urandom);
         d[b] = $urandom;
         rb[b] = rdy_cnt[b];
         sb[b] = rsp_cnt[b];
      end
      model_txn(1'b0, a[first], 32'd0, d[first], 0, 1'b1);
      model_txn(1'b0, a[second], 32'd0, d[second], 0, 1'b1);
      set_req(0, 1'b1, 1'b0, a[0], 32'd0);
      set_req(1, 1'b1, 1'b0, a[1], 32'd0);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         #1;
         got = (rdy_cnt[0] != rb[0]) || (rdy_cnt[1] != rb[1]);
      end
      chk({tag, " any_ready"}, 64'(got), 64'd1);
      chk({tag, " first_rdy"}, 64'(rdy_cnt[first] - rb[first]), 64'd1);
      chk({tag, " second_wait"}, 64'(rdy_cnt[second] - rb[second]), 64'd0);
      set_req(first, 1'b0, 1'b0, 24'd0, 32'd0);
      wait_rsp(first, sb[first], tag);
      chk({tag, " first_rdata"}, 64'(cap_rdata), 64'(d[first]));
      wait_rdy(second, rb[second], tag);
      set_req(second, 1'b0, 1'b0, 24'd0, 32'd0);
      chk({tag, " regrant_gap"},
          64'(rdy_cyc[second] - rsp_cyc[first]), 64'd2);
      wait_rsp(second, sb[second], tag);
      chk({tag, " second_rdata"}, 64'(cap_rdata), 64'(d[second]));
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " rsp_first"}, 64'(rsp_cnt[first] - sb[first]), 64'd1);
      chk({tag, " rsp_second"}, 64'(rsp_cnt[second] - sb[second]), 64'd1);
      chk_frames(tag);
   endtask

   initial begin
      vec_t vecs[5];
      int   sr0, sr1, rr0, rr1, lo;
      bit   got;

      vecs[0] = '{1'b0, 0, 24'h000000, 32'h0, 32'hFF00FF00, 0,
                  32'hFF00FF00, 1'b0};
      vecs[1] = '{1'b1, 1, 24'h000100, 32'hFF00FF00, 32'h0, 2,
                  32'h0, 1'b0};
      vecs[2] = '{1'b1, 0, 24'h3C5A96, 32'h12345678, 32'h0, 9,
                  32'h0, 1'b1};
      vecs[3] = '{1'b0, 1, 24'hABCDEF, 32'h0, 32'h0BADF00D, 0,
                  32'h0BADF00D, 1'b0};
      vecs[4] = '{1'b1, 1, 24'hFFFFFF, 32'h00000001, 32'h0, 3,
                  32'h0, 1'b0};

      rst = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_write = 2'b00;
      bus.req_addr = 48'd0;
      bus.req_wdata = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset css", 64'(bus.s_css), 64'd1);
      chk("reset tx_valid", 64'(bus.s_tx_valid), 64'd0);
      chk("reset tx_byte", 64'(bus.s_tx_byte), 64'd0);
      chk("reset req_ready", 64'(bus.req_ready), 64'd0);
      chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("reset rsp_err", 64'(bus.rsp_err), 64'd0);
      rst = 1'b0;

      both_round("rr_a");
      both_round("rr_b");

      for (int i = 0; i < 5; i++)
         run_txn(vecs[i].wr, vecs[i].who, vecs[i].addr, vecs[i].wdata,
                 vecs[i].fdata, vecs[i].busy, 1'b0, vecs[i].exp_rdata,
                 vecs[i].exp_err, $sformatf("vec%0d", i));

      // stray engine pulses in idle and between bytes/frames
      stray = 1'b1;
      start_txn();
      sr0 = rsp_cnt[0]; sr1 = rsp_cnt[1];
      rr0 = rdy_cnt[0]; rr1 = rdy_cnt[1];
      lo = css_low_cyc;
      repeat (30) @(posedge clk);
      #1;
      chk("stray mosi", 64'(mosi_log.size()), 64'd0);
      chk("stray css_low", 64'(css_low_cyc - lo), 64'd0);
      chk("stray rsp", 64'((rsp_cnt[0] - sr0) + (rsp_cnt[1] - sr1)), 64'd0);
      chk("stray rdy", 64'((rdy_cnt[0] - rr0) + (rdy_cnt[1] - rr1)), 64'd0);
      max_dly = 2;
      run_txn(1'b1, 0, 24'h010203, 32'hA5A55A5A, 32'h0, 1, 1'b1,
              32'h0, 1'b0, "stray_wr");
      run_txn(1'b0, 1, 24'h040506, 32'h0, 32'hC0FFEE11, 0, 1'b1,
              32'hC0FFEE11, 1'b0, "stray_rd");
      stray = 1'b0;
      max_dly = 0;

      both_round("rr_c");

      // reset during the third address byte
      start_txn();
      model_txn(1'b0, 24'h123456, 32'h0, 32'h87654321, 0, 1'b0);
      sr0 = rsp_cnt[0];
      set_req(0, 1'b1, 1'b0, 24'h123456, 32'h0);
      wait_rdy(0, rdy_cnt[0], "rst");
      set_req(0, 1'b0, 1'b0, 24'h0, 32'h0);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk);
         #1;
         got = (mosi_log.size() == 3) && bus.s_tx_valid;
      end
      chk("rst reached_addr2", 64'(got), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst css", 64'(bus.s_css), 64'd1);
      chk("rst tx_valid", 64'(bus.s_tx_valid), 64'd0);
      chk("rst tx_byte", 64'(bus.s_tx_byte), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rr_exp = 0;
      rxq.delete();
      repeat (30) @(posedge clk);
      #1;
      chk("rst no_rsp", 64'(rsp_cnt[0] - sr0), 64'd0);
      run_txn(1'b0, 0, 24'h00ABCD, 32'h0, 32'hDEADBEEF, 0, 1'b1,
              32'hDEADBEEF, 1'b0, "rst_read");
      both_round("rr_after_rst");

      for (int i = 0; i < 24; i++) begin
         bit          wr;
         int          who, busy;
         logic [31:0] fd;
         wr = 1'($urandom_range(0, 1));
         who = $urandom_range(0, 1);
         busy = $urandom_range(0, 6);
         fd = $urandom;
         stray = 1'($urandom_range(0, 1));
         max_dly = $urandom_range(0, 3);
         run_txn(wr, who, 24'($urandom), $urandom, fd, busy, 1'b1,
                 wr ? 32'd0 : fd, wr && (busy >= PMAX),
                 $sformatf("rnd%0d", i));
      end
      stray = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
